// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite OAM DMA engine: copies one 256-byte CPU page into OAM while stalling the CPU
//
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   clk_en          : CPU-cycle enable; all state advances only on enabled edges
//   start           : $4014 write strobe, sampled on enabled cycles while idle
//   page            : source page (high byte of CPU address), captured with start
//   oam_addr_base   : current OAMADDR, captured with start
//   mem_addr/mem_re : CPU bus read request, asserted only in GET
//   mem_rdata       : read data, valid in the enabled cycle after the GET cycle
//   oam_addr/oam_we/oam_wdata : OAM write port, asserted only in PUT
//   cpu_stall, busy : high whenever a transfer is in progress

module oam_dma (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [7:0]  page,
    input  logic [7:0]  oam_addr_base,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    output logic        cpu_stall,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_GET   = 3'd3;
    localparam logic [2:0] S_PUT   = 3'd4;

    logic [2:0] state_q, state_d;
    logic       parity_q, parity_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] page_q, page_d;
    logic [7:0] base_q, base_d;

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;
        page_d   = page_q;
        base_d   = base_q;
        if (clk_en) begin
            parity_d = ~parity_q;
            case (state_q)
                S_IDLE: begin
                    // start is only honoured here, so strobes during a transfer
                    // (including the final PUT) never restart or recapture.
                    if (start) begin
                        state_d = S_HALT;
                        page_d  = page;
                        base_d  = oam_addr_base;
                        cnt_d   = 8'h00;
                    end
                end
                S_HALT: begin
                    // The cycle after HALT has parity ~parity_q; reads must start
                    // on an even cycle, so an odd successor needs one ALIGN cycle.
                    state_d = parity_q ? S_GET : S_ALIGN;
                end
                S_ALIGN: state_d = S_GET;
                S_GET:   state_d = S_PUT;
                S_PUT: begin
                    cnt_d   = cnt_q + 8'h01;
                    state_d = (cnt_q == 8'hFF) ? S_IDLE : S_GET;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            cnt_q    <= 8'h00;
            page_q   <= 8'h00;
            base_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
            page_q   <= page_d;
            base_q   <= base_d;
        end
    end

    logic in_get;
    logic in_put;

    // Outputs are pure state decodes so a reset clears them in the same cycle
    // and they cannot move while clk_en holds the state.
    always_comb begin
        in_get    = (state_q == S_GET);
        in_put    = (state_q == S_PUT);
        busy      = (state_q != S_IDLE);
        cpu_stall = busy;
        mem_re    = in_get;
        mem_addr  = in_get ? {page_q, cnt_q} : 16'h0000;
        oam_we    = in_put;
        oam_addr  = in_put ? (base_q + cnt_q) : 8'h00;
        oam_wdata = in_put ? mem_rdata : 8'h00;
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for oam_dma
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  page = 8'h00;
    logic [7:0]  base = 8'h00;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic        cpu_stall;
    logic        busy;

    always #5 clk = ~clk;

    oam_dma dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .start         (start),
        .page          (page),
        .oam_addr_base (base),
        .mem_addr      (mem_addr),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata),
        .oam_addr      (oam_addr),
        .oam_we        (oam_we),
        .oam_wdata     (oam_wdata),
        .cpu_stall     (cpu_stall),
        .busy          (busy)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // CPU memory contents as a fixed pattern of the address
    function automatic logic [7:0] ram_val(input logic [15:0] a);
        logic [7:0] h;
        logic [7:0] hi;
        h  = a[7:0] * 8'd7 + 8'h5A;
        hi = a[15:8] * 8'd29;
        return h ^ hi;
    endfunction

    // Read data appears in the enabled cycle after the read request
    always @(posedge clk) begin
        if (clk_en && mem_re) mem_rdata <= ram_val(mem_addr);
    end

    // Bench copy of the CPU cycle parity
    logic tb_par;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_par <= 1'b0;
        else if (clk_en) tb_par <= ~tb_par;
    end

    // Scoreboard: {oam_addr, oam_wdata} expected per committed write
    logic [15:0] exp_q[$];
    logic [7:0]  cur_page;

    int         wr_cnt = 0;
    int         get_idx = 0;
    int         stall_cnt = 0;
    int         gap = 0;
    int         first_gap = 0;
    int         first_par = 0;
    int         acc_par = 0;
    bit         tracking = 0;
    logic [7:0] wr_addr_log [256];
    logic [7:0] wr_data_log [256];
    logic [35:0] snap;
    logic [35:0] prev_snap = '0;
    logic        prev_en = 1'b0;
    logic        prev_rst = 1'b0;

    always @(negedge clk) begin
        logic [15:0] e;
        snap = {mem_addr, mem_re, oam_addr, oam_we, oam_wdata, cpu_stall, busy};
        if (!rst_n) begin
            chk("rst_outputs", snap, 36'h0);
            tracking = 0;
        end else begin
            if (prev_rst && !prev_en) chk("hold_when_disabled", snap, prev_snap);
            if (clk_en) begin
                if (start && !busy) begin
                    acc_par   = tb_par;
                    stall_cnt = 0;
                    gap       = 0;
                    tracking  = 1;
                    wr_cnt    = 0;
                    get_idx   = 0;
                end else if (tracking) begin
                    gap++;
                    if (mem_re) begin
                        tracking  = 0;
                        first_gap = gap;
                        first_par = tb_par;
                    end
                end
                if (cpu_stall) stall_cnt++;
                if (mem_re) begin
                    chk("mem_addr", mem_addr, {cur_page, get_idx[7:0]});
                    get_idx++;
                end
                if (oam_we) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", {oam_addr, oam_wdata}, 16'hxxxx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("oam_write", {oam_addr, oam_wdata}, e);
                    end
                    if (wr_cnt < 256) begin
                        wr_addr_log[wr_cnt] = oam_addr;
                        wr_data_log[wr_cnt] = oam_wdata;
                    end
                    wr_cnt++;
                end
            end
        end
        prev_snap = snap;
        prev_en   = clk_en;
        prev_rst  = rst_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted start (caller keeps clk_en=1) and queues the 256 writes
    task automatic start_xfer(input logic [7:0] pg, input logic [7:0] bs);
        logic [7:0] a;
        cur_page = pg;
        for (int i = 0; i < 256; i++) begin
            a = bs + i[7:0];
            exp_q.push_back({a, ram_val({pg, i[7:0]})});
        end
        page  = pg;
        base  = bs;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("finished_in_budget", busy, 1'b0);
    endtask

    typedef struct {
        logic [7:0] pg;
        logic [7:0] bs;
        logic       odd;
        int         stall;
        int         gap;
    } vec_t;

    initial begin
        vec_t vt[3];
        int   n;
        bit   pulsed;

        vt[0] = '{8'h02, 8'h00, 1'b0, 513, 2};
        vt[1] = '{8'h05, 8'h10, 1'b1, 514, 3};
        vt[2] = '{8'h07, 8'hFC, 1'b0, 513, 2};

        clk_en = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset_busy", busy, 1'b0);

        // Table-driven transfers: parity of accept cycle, stall length, alignment
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (tb_par != vt[i].odd && n < 4) begin
                tick();
                n++;
            end
            start_xfer(vt[i].pg, vt[i].bs);
            wait_idle(2000);
            chk("stall_len", stall_cnt, vt[i].stall);
            chk("first_get_gap", first_gap, vt[i].gap);
            chk("first_get_even", first_par, 0);
            chk("write_count", wr_cnt, 256);
            chk("sb_drained", exp_q.size(), 0);
            if (i == 2) begin
                chk("wrap_first_addr", wr_addr_log[0], 8'hFC);
                chk("wrap_first_data", wr_data_log[0], ram_val(16'h0700));
                chk("wrap_w5_addr", wr_addr_log[4], 8'h00);
                chk("wrap_w5_data", wr_data_log[4], ram_val(16'h0704));
                chk("wrap_last_addr", wr_addr_log[255], 8'hFB);
            end
            repeat (3) tick();
        end

        // Random clk_en gaps plus a start pulse mid-transfer
        start_xfer(8'h03, 8'h20);
        n = 0;
        pulsed = 0;
        while (busy && n < 8000) begin
            clk_en = ($urandom_range(0, 9) < 7);
            if (!pulsed && wr_cnt >= 100) begin
                clk_en = 1'b1;
                start  = 1'b1;
                page   = 8'hAA;
                base   = 8'h55;
                repeat (3) tick();
                start  = 1'b0;
                pulsed = 1;
            end
            tick();
            n++;
        end
        clk_en = 1'b1;
        chk("gaps_finished", busy, 1'b0);
        chk("gaps_write_count", wr_cnt, 256);
        chk("gaps_sb_drained", exp_q.size(), 0);
        chk("gaps_stall_len", stall_cnt, acc_par ? 514 : 513);
        repeat (3) tick();

        // Reset mid-transfer after 40 writes
        start_xfer(8'h04, 8'h00);
        n = 0;
        while (wr_cnt < 40 && n < 2000) begin
            tick();
            n++;
        end
        chk("reached_40_writes", wr_cnt, 40);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs",
            {mem_addr, mem_re, oam_addr, oam_we, oam_wdata, cpu_stall, busy}, 36'h0);
        repeat (3) tick();
        exp_q.delete();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_after_reset", busy, 1'b0);
        start_xfer(8'h04, 8'h80);
        wait_idle(2000);
        chk("post_reset_writes", wr_cnt, 256);
        chk("post_reset_sb", exp_q.size(), 0);
        repeat (3) tick();

        // start coincident with the final PUT is ignored
        start_xfer(8'h06, 8'h33);
        n = 0;
        while (!(oam_we && wr_cnt == 255) && n < 2000) begin
            tick();
            n++;
        end
        chk("at_final_put", oam_we, 1'b1);
        start = 1'b1;
        page  = 8'h11;
        base  = 8'h00;
        tick();
        start = 1'b0;
        chk("final_put_ignored", busy, 1'b0);
        tick();
        chk("still_idle", busy, 1'b0);
        chk("final_write_count", wr_cnt, 256);
        chk("final_sb", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL provide port clk, input, 1 bit: system clock.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-004 SHALL provide port clk_en, input, 1 bit: CPU-cycle enable; all state advances only on clk edges with clk_en=1.
REQ-005 SHALL provide port start, input, 1 bit: $4014 write strobe, sampled on clk_en cycles.
REQ-006 SHALL provide port page, input, 8 bits: source page, high byte of the CPU address, captured with start.
REQ-007 SHALL provide port oam_addr_base, input, 8 bits: current OAMADDR, captured with start.
REQ-008 SHALL provide port mem_addr, output, 16 bits: CPU bus read address.
REQ-009 SHALL provide port mem_re, output, 1 bit: CPU bus read request.
REQ-010 SHALL provide port mem_rdata, input, 8 bits: read data, valid in the clk_en cycle after the mem_re cycle.
REQ-011 SHALL provide port oam_addr, output, 8 bits: OAM write address.
REQ-012 SHALL provide port oam_we, output, 1 bit: OAM write enable; the OAM commits only when clk_en=1.
REQ-013 SHALL provide port oam_wdata, output, 8 bits: OAM write data.
REQ-014 SHALL provide port cpu_stall, output, 1 bit: halts the CPU core.
REQ-015 SHALL provide port busy, output, 1 bit: transfer in progress.

Function
REQ-016 SHALL implement states IDLE, HALT, ALIGN, GET and PUT, with all transitions taken only when clk_en=1.
REQ-017 SHALL keep a parity bit that toggles on every clk_en cycle; reset value 0 (even).
REQ-018 IDLE SHALL go to HALT when start=1, and SHALL capture page and oam_addr_base in the same edge.
REQ-019 HALT SHALL last exactly 1 cycle, then go to GET if the next cycle's parity is even, otherwise to ALIGN.
REQ-020 ALIGN SHALL last exactly 1 cycle, then go to GET.
REQ-021 GET SHALL drive mem_re=1 and mem_addr={page, byte_cnt}, then go to PUT.
REQ-022 PUT SHALL drive oam_we=1, oam_addr=(oam_addr_base+byte_cnt) mod 256 and oam_wdata=mem_rdata.
REQ-023 On leaving PUT, byte_cnt (8 bits) SHALL increment; if byte_cnt was 255, the next state SHALL be IDLE, otherwise GET.
REQ-024 Total stall length SHALL be 513 clk_en cycles when start is accepted in an even cycle and 514 when accepted in an odd cycle.
REQ-025 cpu_stall and busy SHALL equal (state != IDLE), decoded combinationally.
REQ-026 mem_re SHALL be 1 only in GET; oam_we SHALL be 1 only in PUT.
REQ-027 When clk_en=0, state, counters and all outputs SHALL hold.
REQ-028 start asserted while busy SHALL be ignored: no restart and no recapture of page or base.
REQ-029 start asserted on the same clk_en cycle as the final PUT SHALL be ignored; a new transfer begins only from IDLE.
REQ-030 OAM address wraparound: base 0xFC SHALL write 0xFC..0xFF, then 0x00..0xFB.
REQ-031 mem_addr SHALL never leave the captured page: low byte 0x00..0xFF, no carry into the high byte.

Reset
REQ-032 While rst_n=0: state=IDLE, parity=0, byte_cnt=0, and page/base registers = 0.
REQ-033 While rst_n=0, all outputs SHALL be 0: mem_addr=0, mem_re=0, oam_addr=0, oam_we=0, oam_wdata=0, cpu_stall=0, busy=0.
REQ-034 Reset asserted mid-transfer SHALL abort immediately: no further oam_we and no mem_re.
REQ-035 After release from a mid-transfer reset, the block SHALL wait in IDLE for a new start.

Verification
REQ-036 Bench SHALL apply reset, then start with page=0x02 and base=0x00 on the first clk_en (even) -> cpu_stall high exactly 513 clk_en cycles; 256 writes with OAM[i]=RAM[0x0200+i].
REQ-037 Bench SHALL apply start on an odd cycle -> one ALIGN cycle; cpu_stall high exactly 514 clk_en cycles; first mem_re lands on an even cycle.
REQ-038 Bench SHALL apply base=0xFC, page=0x07 -> first write oam_addr=0xFC with data RAM[0x0700]; write 5 at oam_addr=0x00 with data RAM[0x0704]; last write at 0xFB.
REQ-039 Bench SHALL pulse start again at byte 100, and hold clk_en=0 for random stretches -> no restart, 256 writes total, outputs stable while clk_en=0.
REQ-040 Bench SHALL assert rst_n=0 after 40 writes -> all outputs 0 within the same cycle, no more writes; a new start then performs a full 256-byte transfer.
REQ-041 Bench SHALL assert start coincident with the final PUT -> ignored; busy=0 on the next clk_en cycle.
